// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// halt opcode and the opcode field position within an instruction word.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam logic [3:0]  HALT_OPCODE = 4'b0000;
  localparam int unsigned OPC_MSB     = 15;
  localparam int unsigned OPC_LSB     = 12;
  localparam int unsigned OPC_W       = OPC_MSB - OPC_LSB + 1;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, the program ROM and the decode stage.
// master = sequencer side, slave = ROM/decode/branch-unit side.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned INSTR_W = 16
) ();

  logic [ADDR_W-1:0]  rom_address;
  logic [INSTR_W-1:0] rom_instruction;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_addr;

  modport master (
    output rom_address,
    input  rom_instruction,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    input  redirect_valid,
    input  redirect_addr
  );

  modport slave (
    input  rom_address,
    output rom_instruction,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    output redirect_valid,
    output redirect_addr
  );

endinterface

// File: rtl/pc_counter.sv
// Loadable, enable-gated program counter; terminal flags the last ROM address.
// Increment wraps modulo 2**ADDR_W.
module pc_counter #(
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              enable,
  output logic [ADDR_W-1:0] count,
  output logic              terminal
);

  logic [ADDR_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_addr;
    end else if (enable) begin
      count_q <= count_q + ADDR_W'(1);
    end
  end

  assign count    = count_q;
  assign terminal = (count_q == '1);

endmodule

// File: rtl/fetch_sequencer.sv
// PC/fetch controller for a combinational program ROM with a valid/ready decode port.
// Define FETCH_WRAP_EN to wrap fetch past the last address instead of halting there.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned INSTR_W     = 16,
  parameter logic [3:0]  HALT_OPCODE = fetch_pkg::HALT_OPCODE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  fetch_sequencer_if.master  bus,
  output logic               halted,
  output logic               busy
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
  // Last address has been delivered; stop fetching once it drains.
  logic               done_q, done_d;

  logic               pc_load;
  logic [ADDR_W-1:0]  pc_load_addr;
  logic               pc_inc;
  logic [ADDR_W-1:0]  pc;
  logic               pc_terminal;

  logic               slot_free;
  logic               is_halt;

  pc_counter #(
    .ADDR_W (ADDR_W)
  ) u_pc_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pc_load),
    .load_addr (pc_load_addr),
    .enable    (pc_inc),
    .count     (pc),
    .terminal  (pc_terminal)
  );

`ifdef FETCH_WRAP_EN
  logic unused_terminal;
  assign unused_terminal = pc_terminal;
`endif

  assign slot_free = !instr_valid_q || bus.instr_ready;
  assign is_halt   = (bus.rom_instruction[INSTR_W-1 -: OPC_W] == HALT_OPCODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    done_d        = done_q;
    pc_load       = 1'b0;
    pc_load_addr  = '0;
    pc_inc        = 1'b0;

    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          pc_load       = 1'b1;
          state_d       = RUN;
          instr_valid_d = 1'b0;
          done_d        = 1'b0;
        end
      end
      RUN: begin
        if (bus.redirect_valid) begin
          // Flush wins even if decode is accepting this cycle.
          pc_load       = 1'b1;
          pc_load_addr  = bus.redirect_addr;
          instr_valid_d = 1'b0;
          done_d        = 1'b0;
        end else if (done_q) begin
          if (slot_free) begin
            state_d       = HALTED;
            instr_valid_d = 1'b0;
            done_d        = 1'b0;
          end
        end else if (slot_free) begin
          if (is_halt) begin
            state_d       = HALTED;
            instr_valid_d = 1'b0;
          end else begin
            instr_d       = bus.rom_instruction;
            instr_pc_d    = pc;
            instr_valid_d = 1'b1;
            pc_inc        = 1'b1;
`ifndef FETCH_WRAP_EN
            done_d        = pc_terminal;
`endif
          end
        end
      end
      default: begin
        state_d       = IDLE;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.rom_address = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign halted          = (state_q == HALTED);
  assign busy            = (state_q == RUN);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected {pc, word} transfers,
// a negedge monitor pops and compares each accepted instruction.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halted;
  logic        busy;
  logic [15:0] rom [8];

  int checks;
  int errors;
  logic [18:0] exp_q[$];

  fetch_sequencer_if #(.ADDR_W(3), .INSTR_W(16)) bus ();

  assign bus.rom_instruction = rom[bus.rom_address];

  fetch_sequencer #(
    .ADDR_W  (3),
    .INSTR_W (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bus    (bus.master),
    .halted (halted),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Monitor: a transfer is valid && ready without a same-cycle flush.
  always @(negedge clk) begin
    if (rst_n && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected got pc=%0d instr=%h required none", bus.instr_pc,
                 bus.instr);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        if ({bus.instr_pc, bus.instr} !== e) begin
          errors++;
          $display("FAIL xfer got pc=%0d instr=%h required pc=%0d instr=%h", bus.instr_pc,
                   bus.instr, e[18:16], e[15:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] pc, input logic [15:0] w);
    exp_q.push_back({pc, w});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halted(input int budget);
    for (int i = 0; i < budget && !halted; i++) tick();
    check("wait_halted", 32'(halted), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] init_rom [8];
    init_rom = '{16'h1C0A, 16'h1400, 16'h2222, 16'h3333,
                 16'h4444, 16'h5555, 16'h6666, 16'h7777};
    checks = 0;
    errors = 0;
    rom = init_rom;
    rst_n = 1'b0;
    start = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr = '0;

    // Reset state
    repeat (2) tick();
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rom_address", 32'(bus.rom_address), 32'd0);
    check("rst_instr", 32'(bus.instr), 32'd0);
    check("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Streaming, backpressure, redirect and end-of-program
    bus.instr_ready = 1'b1;
    push(3'd0, 16'h1C0A);
    push(3'd1, 16'h1400);
    pulse_start();
    check("start_cycle_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    check("first_pc", 32'(bus.instr_pc), 32'd0);
    check("first_busy", 32'(busy), 32'd1);
    tick();
    check("second_pc", 32'(bus.instr_pc), 32'd1);
    bus.instr_ready = 1'b0;
    push(3'd1, 16'h1400);
    exp_q.delete(exp_q.size() - 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(bus.instr_valid), 32'd1);
      check("stall_instr", 32'(bus.instr), 32'h1400);
      check("stall_pc", 32'(bus.instr_pc), 32'd1);
      check("stall_rom_address", 32'(bus.rom_address), 32'd2);
    end
    bus.instr_ready = 1'b1;
    tick();
    check("after_stall_pc", 32'(bus.instr_pc), 32'd2);
    check("after_stall_instr", 32'(bus.instr), 32'h2222);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 3'd6;
    push(3'd6, 16'h6666);
    push(3'd7, 16'h7777);
`ifdef FETCH_WRAP_EN
    push(3'd0, 16'h1C0A);
`endif
    tick();
    bus.redirect_valid = 1'b0;
    check("redirect_flush", 32'(bus.instr_valid), 32'd0);
`ifdef FETCH_WRAP_EN
    wait_drain(20);
    check("wrap_not_halted", 32'(halted), 32'd0);
    bus.instr_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`else
    wait_halted(20);
    check("eop_busy", 32'(busy), 32'd0);
    check("eop_valid", 32'(bus.instr_valid), 32'd0);
    check("eop_queue", 32'(exp_q.size()), 32'd0);
`endif

    // Halt opcode at address 3
    rom[3] = 16'h0000;
    bus.instr_ready = 1'b1;
    push(3'd0, 16'h1C0A);
    push(3'd1, 16'h1400);
    push(3'd2, 16'h2222);
    pulse_start();
    wait_halted(20);
    check("halt_valid", 32'(bus.instr_valid), 32'd0);
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_instr_pc", 32'(bus.instr_pc), 32'd2);
    check("halt_rom_address", 32'(bus.rom_address), 32'd3);
    check("halt_queue", 32'(exp_q.size()), 32'd0);
    tick();
    check("halt_stays", 32'(halted), 32'd1);

    // Restart from HALTED, stall, then asynchronous reset mid-stall
    bus.instr_ready = 1'b0;
    pulse_start();
    tick();
    check("restart_valid", 32'(bus.instr_valid), 32'd1);
    check("restart_pc", 32'(bus.instr_pc), 32'd0);
    check("restart_instr", 32'(bus.instr), 32'h1C0A);
    check("restart_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.instr_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_halted", 32'(halted), 32'd0);
    check("async_rst_rom_address", 32'(bus.rom_address), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    repeat (3) tick();
    check("post_rst_idle_busy", 32'(busy), 32'd0);
    check("post_rst_idle_valid", 32'(bus.instr_valid), 32'd0);

    // Full program without a halt word
    rom = init_rom;
    for (int i = 0; i < 8; i++) push(3'(i), init_rom[i]);
`ifdef FETCH_WRAP_EN
    push(3'd0, 16'h1C0A);
    push(3'd1, 16'h1400);
    pulse_start();
    wait_drain(30);
    check("wrap_full_not_halted", 32'(halted), 32'd0);
`else
    pulse_start();
    wait_halted(30);
    check("full_queue", 32'(exp_q.size()), 32'd0);
    check("full_valid", 32'(bus.instr_valid), 32'd0);
`endif
    repeat (2) tick();
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
